// File: rtl/zx_char_writer.sv
// Plots one 8x8 character cell into ZX Spectrum screen memory: eight glyph
// lines at the scrambled bitmap addresses, then the attribute byte.
module zx_char_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  col,
    input  logic [4:0]  row,
    input  logic [7:0]  char_code,
    input  logic [7:0]  attr,
    input  logic        invert,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [12:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    input  logic        vram_ack
);

    typedef enum logic [2:0] {
        IDLE,
        FADDR,
        FDATA,
        WR,
        ATTR,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  line_q, line_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic        inv_q, inv_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            char_q  <= '0;
            attr_q  <= '0;
            inv_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            col_q   <= col_d;
            row_q   <= row_d;
            char_q  <= char_d;
            attr_q  <= attr_d;
            inv_q   <= inv_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        col_d   = col_q;
        row_d   = row_q;
        char_d  = char_q;
        attr_d  = attr_q;
        inv_d   = inv_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (row > 5'd23) begin
                        err_d = 1'b1;
                    end else begin
                        col_d   = col;
                        row_d   = row;
                        char_d  = char_code;
                        attr_d  = attr;
                        inv_d   = invert;
                        line_d  = '0;
                        state_d = FADDR;
                    end
                end
            end
            FADDR: state_d = FDATA;
            FDATA: begin
                // Spectrum bitmap order: third, pixel line, char row, column
                wdata_d = font_data ^ {8{inv_q}};
                addr_d  = {row_q[4:3], line_q, row_q[2:0], col_q};
                state_d = WR;
            end
            WR: begin
                if (vram_ack) begin
                    if (line_q == 3'd7) begin
                        addr_d  = {3'b110, row_q, col_q};
                        wdata_d = attr_q;
                        state_d = ATTR;
                    end else begin
                        line_d  = line_q + 3'd1;
                        state_d = FADDR;
                    end
                end
            end
            ATTR: begin
                if (vram_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        vram_we    = (state_q == WR) || (state_q == ATTR);
        err        = err_q;
        font_addr  = {char_q, line_q};
        vram_addr  = addr_q;
        vram_wdata = wdata_q;
    end

endmodule

// File: tb/tb_zx_char_writer.sv
// Directed bench for zx_char_writer with a behavioural font ROM and a
// VRAM write-port model that can insert ack wait states per write.
module tb_zx_char_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  col;
    logic [4:0]  row;
    logic [7:0]  char_code;
    logic [7:0]  attr;
    logic        invert;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [12:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        vram_ack;

    int n_vec = 0;
    int n_bad = 0;

    logic [12:0] wa [16];
    logic [7:0]  wd [16];
    int          stall [16];
    int          wr_n = 0;
    int          err_cnt = 0;
    int          done_cnt = 0;
    bit          in_wr = 0;
    int          waits = 0;
    logic [12:0] held_a;
    logic [7:0]  held_d;

    zx_char_writer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .col        (col),
        .row        (row),
        .char_code  (char_code),
        .attr       (attr),
        .invert     (invert),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .vram_ack   (vram_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [10:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd73 + 16'd11;
        return t[7:0] ^ t[15:8];
    endfunction

    always @(posedge clk) font_data <= rom_f(font_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        err_cnt  += int'(err);
        done_cnt += int'(done);
        if (done || err) chk("done_err_excl", {31'b0, done & err}, 32'd0);
        if (vram_we) begin
            if (!in_wr) begin
                in_wr  = 1;
                waits  = stall[wr_n % 16];
                held_a = vram_addr;
                held_d = vram_wdata;
            end else begin
                chk("hold_addr", 32'(vram_addr), 32'(held_a));
                chk("hold_data", 32'(vram_wdata), 32'(held_d));
            end
            if (waits > 0) begin
                vram_ack = 1'b0;
                waits--;
            end else begin
                vram_ack = 1'b1;
                if (wr_n < 16) begin
                    wa[wr_n] = vram_addr;
                    wd[wr_n] = vram_wdata;
                end
                wr_n++;
                in_wr = 0;
            end
        end else begin
            vram_ack = 1'b0;
        end
    end

    // Issues a command at the current negedge; returns the done cycle (-1 if none).
    task automatic do_cmd(input logic [4:0] c, input logic [4:0] r, input logic [7:0] ch,
                          input logic [7:0] at, input logic inv, input int poke_cyc,
                          input int rst_cyc, output int dc);
        int n;
        wr_n  = 0;
        in_wr = 0;
        dc    = -1;
        col = c; row = r; char_code = ch; attr = at; invert = inv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        col = ~c; row = 5'd2; char_code = ~ch; attr = ~at; invert = ~inv;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_c1", {31'b0, busy}, 32'd1);
            if (n == poke_cyc) begin
                start = 1'b1;
                col   = 5'd7;
                row   = 5'd24;
            end else begin
                start = 1'b0;
            end
            if (n == rst_cyc) begin
                rst = 1'b1;
                #1;
                chk("rst_we", {31'b0, vram_we}, 32'd0);
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_done", {31'b0, done}, 32'd0);
                chk("rst_err", {31'b0, err}, 32'd0);
                chk("rst_addr", 32'(vram_addr), 32'd0);
                chk("rst_wdata", 32'(vram_wdata), 32'd0);
                chk("rst_faddr", 32'(font_addr), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                break;
            end
            if (done) begin
                dc = n;
                break;
            end
        end
        if (rst_cyc == 0) begin
            if (dc < 0) chk("done_timeout", 32'(n), 32'd0);
            @(negedge clk);
            chk("busy_after", {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic verify(input logic [4:0] c, input logic [4:0] r, input logic [7:0] ch,
                          input logic [7:0] at, input logic inv);
        int base;
        chk("wr_count", 32'(wr_n), 32'd9);
        base = (int'(r) / 8) * 2048 + (int'(r) % 8) * 32 + int'(c);
        for (int i = 0; i < 8; i++) begin
            chk("bm_addr", 32'(wa[i]), 32'(base + i * 256));
            chk("bm_data", 32'(wd[i]), 32'(rom_f({ch, 3'(i)}) ^ (inv ? 8'hFF : 8'h00)));
        end
        chk("at_addr", 32'(wa[8]), 32'(6144 + int'(r) * 32 + int'(c)));
        chk("at_data", 32'(wd[8]), 32'(at));
    endtask

    initial begin
        int dc;
        int d0;
        for (int i = 0; i < 16; i++) stall[i] = 0;
        rst = 1'b1; start = 1'b0; col = '0; row = '0; char_code = '0;
        attr = '0; invert = 1'b0; vram_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err", {31'b0, err}, 32'd0);
        chk("reset_we", {31'b0, vram_we}, 32'd0);
        chk("reset_addr", 32'(vram_addr), 32'd0);
        chk("reset_wdata", 32'(vram_wdata), 32'd0);
        chk("reset_faddr", 32'(font_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // top-left cell
        do_cmd(5'd0, 5'd0, 8'h41, 8'h47, 1'b0, 0, 0, dc);
        chk("tl_done_cyc", 32'(dc), 32'd26);
        verify(5'd0, 5'd0, 8'h41, 8'h47, 1'b0);
        chk("tl_addr7", 32'(wa[7]), 32'h0700);
        chk("tl_attr", 32'(wa[8]), 32'h1800);

        // bottom-right cell, inverted
        do_cmd(5'd31, 5'd23, 8'h9C, 8'hC5, 1'b1, 0, 0, dc);
        chk("br_done_cyc", 32'(dc), 32'd26);
        verify(5'd31, 5'd23, 8'h9C, 8'hC5, 1'b1);
        chk("br_addr0", 32'(wa[0]), 32'h10FF);
        chk("br_addr7", 32'(wa[7]), 32'h17FF);
        chk("br_attr", 32'(wa[8]), 32'h1AFF);

        // mid-screen scramble
        do_cmd(5'd5, 5'd9, 8'h33, 8'h38, 1'b0, 0, 0, dc);
        verify(5'd5, 5'd9, 8'h33, 8'h38, 1'b0);
        chk("mid_addr0", 32'(wa[0]), 32'h0825);
        chk("mid_addr3", 32'(wa[3]), 32'h0B25);
        chk("mid_attr", 32'(wa[8]), 32'h1925);

        // ack stalls: 3 on line 2, 2 on the attribute write
        stall[2] = 3;
        stall[8] = 2;
        do_cmd(5'd12, 5'd17, 8'h7E, 8'h0F, 1'b0, 0, 0, dc);
        stall[2] = 0;
        stall[8] = 0;
        chk("stall_done_cyc", 32'(dc), 32'd31);
        verify(5'd12, 5'd17, 8'h7E, 8'h0F, 1'b0);

        // illegal row
        wr_n = 0;
        d0 = err_cnt;
        row = 5'd24; col = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("ill_err_c1", {31'b0, err}, 32'd1);
        chk("ill_busy_c1", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("ill_err_c2", {31'b0, err}, 32'd0);
        repeat (4) @(negedge clk);
        chk("ill_busy", {31'b0, busy}, 32'd0);
        chk("ill_writes", 32'(wr_n), 32'd0);
        chk("ill_err_pulses", 32'(err_cnt - d0), 32'd1);

        // start while busy is ignored
        d0 = err_cnt;
        do_cmd(5'd20, 5'd4, 8'hA5, 8'h71, 1'b0, 10, 0, dc);
        chk("busy_done_cyc", 32'(dc), 32'd26);
        verify(5'd20, 5'd4, 8'hA5, 8'h71, 1'b0);
        chk("busy_no_err", 32'(err_cnt - d0), 32'd0);

        // reset during the line-4 write
        do_cmd(5'd1, 5'd1, 8'h10, 8'h22, 1'b0, 0, 15, dc);
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_idle_busy", {31'b0, busy}, 32'd0);
        do_cmd(5'd9, 5'd14, 8'h5B, 8'hB8, 1'b1, 0, 0, dc);
        chk("rst_after_cyc", 32'(dc), 32'd26);
        verify(5'd9, 5'd14, 8'h5B, 8'hB8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/zx_char_writer.md
# zx_char_writer

Character plotter for the ZX Spectrum screen memory: the writer-side counterpart of the VGA scan-out that reads the 6912-byte screen image. It takes one character cell request (column, row, character code, attribute), reads 8 glyph lines from a synchronous font ROM, and writes them into video RAM using the Spectrum's scrambled bitmap addressing, followed by the attribute byte. It sits between a host/CPU-side command source and the write port of the shared video RAM, with a wait-state handshake towards the RAM.

## Interface
Parameters:
- none; the geometry is fixed at 32×24 cells, 8 lines per cell, and a 13-bit VRAM address.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; accepted only while busy=0.
- col  in  5  cell column, 0..31.
- row  in  5  cell row; 0..23 are valid.
- char_code  in  8  glyph index into the font ROM.
- attr  in  8  attribute byte: [7] flash, [6] bright, [5:3] paper, [2:0] ink.
- invert  in  1  when 1, each glyph byte is XORed with 8'hFF before it is written.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse when the cell has been fully written.
- err  out  1  one-cycle pulse when start is given with row>23; no writes are made.
- font_addr  out  11  {char_code, line[2:0]}, where line is the glyph line 0..7.
- font_data  in  8  glyph byte; valid in the cycle after the matching font_addr.
- vram_addr  out  13  write address.
- vram_wdata  out  8  write data.
- vram_we  out  1  write request; held, with addr and data stable, until vram_ack.
- vram_ack  in  1  write accepted in the current cycle when vram_ack and vram_we are both 1.

## Operation
- At start in IDLE with busy=0, col, row, char_code, attr and invert are latched. Later changes to these inputs are ignored until the next command.
- If row>23, err=1 for one cycle, the block stays in IDLE, and busy stays 0.
- A start while busy=1 is ignored, with no effect and no error.
- States are IDLE, FADDR, FDATA, WR, ATTR and DONE.
  - FADDR: drive font_addr={char_code,line}, then go to FDATA.
  - FDATA: capture font_data, XOR it with {8{invert}}, load vram_wdata, and load vram_addr={row[4:3], line[2:0], row[2:0], col[4:0]}. Go to WR.
  - WR: vram_we=1. Stay in WR while vram_ack=0. On ack, if line=7 go to ATTR; otherwise increment line and go to FADDR.
  - ATTR: vram_addr={3'b110, row[4:0], col[4:0]} (13'h1800+row*32+col) and vram_wdata=attr. These are loaded on entry. vram_we=1 until ack, then go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- line is a 3-bit counter that is reset to 0 on every accepted start. It never wraps within a command.
- vram_we is 0 in every state except WR and ATTR. vram_we drops in the cycle after the ack.
- Reset values: state=IDLE, line=0. busy, done, err, vram_we, vram_addr, vram_wdata and font_addr are all 0.
- A reset mid-command drops vram_we asynchronously, abandons the command, and leaves any partially written cell as-is.

## Timing
- Accepted start is sampled at edge 0, so busy=1 from cycle 1.
- With vram_ack tied to 1:
  - line n occupies cycles 3n+1 (FADDR), 3n+2 (FDATA) and 3n+3 (WR).
  - ATTR is cycle 25.
  - DONE (done=1) is cycle 26.
  - busy=0 from cycle 27, which is the earliest next start.
- Each cycle in which vram_ack=0 during WR or ATTR adds exactly one cycle to the total.
- The font ROM latency is exactly one cycle. font_data is sampled only in FDATA.
- The err pulse is in cycle 1 after the rejected start; busy stays 0 throughout.
- done and err are never both high in the same cycle.

## Test plan
- Top-left cell: col=0, row=0, char_code=8'h41, attr=8'h47, invert=0, ack=1.
  - Writes go to 13'h0000, 0100, 0200, …, 0700, with the ROM bytes for 8'h41 in line order, then 13'h1800←8'h47.
  - done is in cycle 26.
- Bottom-right cell with invert: col=31, row=23, invert=1.
  - Bitmap writes go to 13'h10FF, 11FF, …, 17FF, each carrying ~ROM byte.
  - The attribute write goes to 13'h1AFF←attr.
- Mid-screen scramble check: row=9, col=5.
  - Bitmap addresses are {01, line, 001, 00101}, i.e. 13'h0825+line*256.
  - The attribute address is 13'h1925.
- Ack stall: ack=0 for 3 cycles on the line-2 write and 2 cycles on ATTR.
  - vram_addr and vram_wdata stay stable while vram_we is held.
  - done moves to cycle 31.
  - Exactly 9 writes are made in total.
- Illegal row and busy start:
  - start with row=24 gives err=1 in cycle 1, no vram_we, and busy=0.
  - A start at cycle 10 of a valid command is ignored: the latched fields are unchanged and there are 9 writes only.
- Reset mid-operation: assert rst during the line-4 WR state.
  - vram_we=0 immediately, all outputs take their reset values, and there is no done.
  - A new start after reset completes normally in 26 cycles.
